// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Sequenced multi-domain reset controller for board top-levels. The block sits
// between the PLL instances and the SoC. It synchronises the PLL lock flags,
// debounces the active-low user button and stretches the reset. It then
// releases the domain resets one at a time, with resets_o[0] first. It also
// counts how often a lock loss aborted an active sequence.
//
// Ports:
//   clk            in   free-running sequencer clock
//   reset_n_i      in   asynchronous active-low reset
//   locks_i        in   [NUM_LOCKS]  PLL locked flags (asynchronous)
//   btn_n_i        in   raw user reset button, low = pressed (asynchronous)
//   resets_o       out  [NUM_RESETS] active-high domain resets (flop driven)
//   ready_o        out  high once every domain reset has been released
//   fault_count_o  out  [8] saturating count of lock-loss aborts
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_LOCKS       = 3,
  parameter int NUM_RESETS      = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 16,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [NUM_LOCKS-1:0]  locks_i,
  input  logic                  btn_n_i,
  output logic [NUM_RESETS-1:0] resets_o,
  output logic                  ready_o,
  output logic [7:0]            fault_count_o
);

  // The stretch and stagger phases never overlap, so they share one counter.
  localparam int SEQ_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX < 2) ? 1 : $clog2(SEQ_MAX);
  localparam int DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int IDX_W   = (NUM_RESETS < 2) ? 1 : $clog2(NUM_RESETS);

  localparam logic [SEQ_W-1:0] STRETCH_LAST = SEQ_W'(STRETCH_CYCLES - 1);
  localparam logic [SEQ_W-1:0] STAGGER_LAST = SEQ_W'(STAGGER_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RESETS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0]                r_btn_sync;
  logic                                  r_btn_db;
  logic [DB_W-1:0]                       r_db_cnt;
  state_t                                r_state;
  logic [SEQ_W-1:0]                      r_cnt;
  logic [IDX_W-1:0]                      r_idx;
  logic [NUM_RESETS-1:0]                 r_resets;
  logic                                  r_ready;
  logic [7:0]                            r_fault;

  logic [NUM_LOCKS-1:0] w_locks_synced;
  logic                 w_btn_synced;
  logic                 w_lock_lost;
  logic                 w_ok;

  assign w_locks_synced = r_lock_sync[SYNC_STAGES-1];
  assign w_btn_synced   = r_btn_sync[SYNC_STAGES-1];
  assign w_lock_lost    = ~(&w_locks_synced);
  assign w_ok           = ~w_lock_lost & r_btn_db;

  // Synchroniser chains for the asynchronous lock flags and the button.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lock_sync <= '0;
      r_btn_sync  <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locks_i};
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_n_i};
    end
  end

  // Button debounce: the debounced level follows the synced button only after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (w_btn_synced != r_btn_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_db <= w_btn_synced;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Sequencer FSM with registered resets, ready flag and fault counter.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_HOLD;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_resets <= '1;
      r_ready  <= 1'b0;
      r_fault  <= 8'd0;
    end else if ((r_state != ST_HOLD) && !w_ok) begin
      // Abort: every domain is reasserted together. Only a lock loss counts as
      // a fault, and a simultaneous button press does not count it twice.
      r_state  <= ST_HOLD;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_resets <= '1;
      r_ready  <= 1'b0;
      if (w_lock_lost && (r_fault != 8'hFF)) begin
        r_fault <= r_fault + 8'd1;
      end
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_cnt    <= '0;
          r_idx    <= '0;
          r_resets <= '1;
          r_ready  <= 1'b0;
          if (w_ok) begin
            r_state <= ST_STRETCH;
          end
        end
        ST_STRETCH: begin
          if (r_cnt == STRETCH_LAST) begin
            r_state  <= ST_RELEASE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_resets <= {NUM_RESETS{1'b1}} << 1'b1;
          end else begin
            r_cnt <= r_cnt + SEQ_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == STAGGER_LAST) begin
            r_cnt <= '0;
            if (r_idx < IDX_LAST) begin
              // Domains are released from bit 0 upward, so the still-held
              // resets are always a contiguous run at the top of the vector.
              r_idx    <= r_idx + IDX_W'(1);
              r_resets <= r_resets << 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + SEQ_W'(1);
          end
        end
        ST_RUN: begin
          r_resets <= '0;
          r_ready  <= 1'b1;
        end
        default: begin
          r_state  <= ST_HOLD;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_resets <= '1;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign resets_o      = r_resets;
  assign ready_o       = r_ready;
  assign fault_count_o = r_fault;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer with default parameters. A
// behavioural model tracks how long the sequence has run without
// interruption. It derives every output from that elapsed time and compares
// the result with the DUT on every falling clock edge. Literal checks pin the
// documented release offsets and the fault-count values.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int NL = 3;
  localparam int NR = 3;
  localparam int SS = 2;
  localparam int DB = 16;
  localparam int SC = 16;
  localparam int SG = 8;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic [NL-1:0] locks_i;
  logic          btn_n_i;
  logic [NR-1:0] resets_o;
  logic          ready_o;
  logic [7:0]    fault_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state. m_prog is -1 while held, otherwise the number of edges since
  // the sequence left HOLD.
  int            m_prog;
  logic [7:0]    m_fault;
  logic [NL-1:0] m_lsync [SS];
  logic          m_bsync [SS];
  logic          m_db;
  int            m_run;

  reset_sequencer #(
    .NUM_LOCKS      (NL),
    .NUM_RESETS     (NR),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .STRETCH_CYCLES (SC),
    .STAGGER_CYCLES (SG)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .locks_i      (locks_i),
    .btn_n_i      (btn_n_i),
    .resets_o     (resets_o),
    .ready_o      (ready_o),
    .fault_count_o(fault_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Domain k is free once elapsed time passes STRETCH plus k staggers.
  function automatic logic [NR-1:0] exp_resets(input int p);
    logic [NR-1:0] r;
    for (int k = 0; k < NR; k++) begin
      r[k] = (p < 0) || (p < SC + k * SG);
    end
    return r;
  endfunction

  function automatic logic exp_ready(input int p);
    return (p >= SC + NR * SG);
  endfunction

  task automatic model_reset();
    m_prog  = -1;
    m_fault = 8'd0;
    m_db    = 1'b1;
    m_run   = 0;
    for (int i = 0; i < SS; i++) begin
      m_lsync[i] = '0;
      m_bsync[i] = 1'b0;
    end
  endtask

  // Behavioural model, advanced on each rising edge from pre-edge values.
  initial begin : model
    logic [NL-1:0] sl;
    logic          sb;
    logic          lost;
    logic          ok;
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n_i);
      if (!reset_n_i) begin
        model_reset();
      end else begin
        sl   = m_lsync[SS-1];
        sb   = m_bsync[SS-1];
        lost = (sl != {NL{1'b1}});
        ok   = !lost && m_db;
        if (m_prog < 0) begin
          if (ok) m_prog = 0;
        end else if (!ok) begin
          if (lost && m_fault != 8'd255) m_fault = m_fault + 8'd1;
          m_prog = -1;
        end else if (m_prog < 1000000) begin
          m_prog = m_prog + 1;
        end
        if (sb != m_db) begin
          m_run = m_run + 1;
          if (m_run == DB) begin
            m_db  = sb;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
        for (int i = SS - 1; i > 0; i--) begin
          m_lsync[i] = m_lsync[i-1];
          m_bsync[i] = m_bsync[i-1];
        end
        m_lsync[0] = locks_i;
        m_bsync[0] = btn_n_i;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      check("cycle{fault,ready,resets}",
            32'({fault_count_o, ready_o, resets_o}),
            32'({m_fault, exp_ready(m_prog), exp_resets(m_prog)}));
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    reset_n_i = 1'b0;
    locks_i   = 3'b111;
    btn_n_i   = 1'b1;

    // Power-up with everything healthy.
    wait_edges(5);
    check("reset_resets", 32'(resets_o), 32'(3'b111));
    check("reset_fault", 32'(fault_count_o), 32'd0);
    reset_n_i = 1'b1;
    wait_edges(18);
    check("pwr_e18_resets", 32'(resets_o), 32'(3'b111));
    wait_edges(1);
    check("pwr_e19_resets", 32'(resets_o), 32'(3'b110));
    wait_edges(8);
    check("pwr_e27_resets", 32'(resets_o), 32'(3'b100));
    wait_edges(8);
    check("pwr_e35_resets", 32'(resets_o), 32'(3'b000));
    check("pwr_e35_ready", 32'(ready_o), 32'd0);
    wait_edges(8);
    check("pwr_e43_ready", 32'(ready_o), 32'd1);
    check("pwr_fault", 32'(fault_count_o), 32'd0);

    // Staggered lock out of a fresh reset: no fault counted in HOLD.
    reset_n_i = 1'b0;
    locks_i   = 3'b011;
    wait_edges(3);
    reset_n_i = 1'b1;
    wait_edges(100);
    check("stag_held", 32'(resets_o), 32'(3'b111));
    locks_i = 3'b111;
    wait_edges(18);
    check("stag_e18", 32'(resets_o), 32'(3'b111));
    wait_edges(1);
    check("stag_e19", 32'(resets_o), 32'(3'b110));
    wait_edges(24);
    check("stag_ready", 32'(ready_o), 32'd1);
    check("stag_fault", 32'(fault_count_o), 32'd0);

    // Lock loss in RUN for 3 cycles.
    locks_i = 3'b101;
    wait_edges(3);
    check("run_loss_resets", 32'(resets_o), 32'(3'b111));
    check("run_loss_ready", 32'(ready_o), 32'd0);
    check("run_loss_fault", 32'(fault_count_o), 32'd1);
    locks_i = 3'b111;
    wait_edges(18);
    check("restart_e18", 32'(resets_o), 32'(3'b111));
    wait_edges(1);
    check("restart_e19", 32'(resets_o), 32'(3'b110));
    wait_edges(8);
    check("restart_e27", 32'(resets_o), 32'(3'b100));

    // Lock loss mid-RELEASE: all domains reassert together.
    locks_i = 3'b011;
    wait_edges(3);
    check("mid_rel_resets", 32'(resets_o), 32'(3'b111));
    check("mid_rel_fault", 32'(fault_count_o), 32'd2);
    locks_i = 3'b111;
    wait_edges(43);
    check("mid_rel_ready", 32'(ready_o), 32'd1);

    // Short button pulse is filtered out.
    btn_n_i = 1'b0;
    wait_edges(10);
    btn_n_i = 1'b1;
    wait_edges(30);
    check("btn10_ready", 32'(ready_o), 32'd1);
    check("btn10_resets", 32'(resets_o), 32'(3'b000));

    // Long button press aborts without counting a fault.
    btn_n_i = 1'b0;
    wait_edges(20);
    check("btn40_resets", 32'(resets_o), 32'(3'b111));
    check("btn40_fault", 32'(fault_count_o), 32'd2);
    wait_edges(20);
    btn_n_i = 1'b1;
    wait_edges(70);
    check("btn40_ready", 32'(ready_o), 32'd1);
    check("btn40_fault_after", 32'(fault_count_o), 32'd2);

    // Randomised lock and button activity, checked by the model.
    for (int s = 0; s < 40; s++) begin
      locks_i = ($urandom_range(0, 2) == 0) ? NL'($urandom) : 3'b111;
      btn_n_i = ($urandom_range(0, 3) != 0);
      wait_edges(int'($urandom_range(1, 80)));
    end

    // 300 lock-loss aborts saturate the counter.
    locks_i = 3'b111;
    btn_n_i = 1'b1;
    wait_edges(50);
    for (int e = 0; e < 300; e++) begin
      locks_i = NL'($urandom_range(0, 6));
      wait_edges(2);
      locks_i = 3'b111;
      wait_edges(8);
    end
    check("sat_fault", 32'(fault_count_o), 32'd255);

    // Asynchronous reset during STRETCH takes effect without a clock edge.
    wait_edges(3);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_resets", 32'(resets_o), 32'(3'b111));
    check("async_ready", 32'(ready_o), 32'd0);
    check("async_fault", 32'(fault_count_o), 32'd0);
    wait_edges(2);
    reset_n_i = 1'b1;
    wait_edges(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
